// File: rtl/ex_iter_divider.sv
// Iterative radix-2 restoring divider for the execute stage (DIV/MOD, signed and unsigned).
// One quotient bit per cycle on magnitudes; the sign fix-up is folded into the result registers.
module ex_iter_divider #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             div_req,
  input  logic             div_signed,
  input  logic [WIDTH-1:0] div_src1,
  input  logic [WIDTH-1:0] div_src2,
  input  logic             div_ack,
  input  logic             div_flush,
  output logic             div_stall,
  output logic             div_done,
  output logic [WIDTH-1:0] div_quot,
  output logic [WIDTH-1:0] div_rem
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Operand state captured at accept; later changes on the source buses are ignored.
  typedef struct packed {
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] src1;
    logic [WIDTH-1:0] dvs;
  } op_t;

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  op_t              op_q;
  logic [WIDTH-1:0] prem_q;
  logic [WIDTH-1:0] dvd_q;
  logic             done_q;
  logic [WIDTH-1:0] quot_q;
  logic [WIDTH-1:0] rem_q;

  // Accept-time operand conditioning
  logic             sa_d, sb_d;
  logic [WIDTH-1:0] abs1_d, abs2_d;

  always_comb begin
    sa_d   = div_signed & div_src1[WIDTH-1];
    sb_d   = div_signed & div_src2[WIDTH-1];
    abs1_d = sa_d ? -div_src1 : div_src1;
    abs2_d = sb_d ? -div_src2 : div_src2;
  end

  // One restoring step: shift {prem, dvd} left, trial-subtract on WIDTH+1 bits.
  logic [WIDTH:0]   trial_d, diff_d;
  logic             qbit_d;
  logic [WIDTH-1:0] prem_d, dvd_d;
  logic             last_d;

  always_comb begin
    trial_d = {prem_q, dvd_q[WIDTH-1]};
    diff_d  = trial_d - {1'b0, op_q.dvs};
    qbit_d  = ~diff_d[WIDTH];
    prem_d  = qbit_d ? diff_d[WIDTH-1:0] : trial_d[WIDTH-1:0];
    dvd_d   = {dvd_q[WIDTH-2:0], qbit_d};
    last_d  = (cnt_q == CW'(WIDTH - 1));
  end

  // Final results; a zero divisor bypasses the fix-up so the signed case matches the unsigned one.
  logic [WIDTH-1:0] quot_fix_d, rem_fix_d;

  always_comb begin
    if (op_q.dvs == '0) begin
      quot_fix_d = '1;
      rem_fix_d  = op_q.src1;
    end else begin
      quot_fix_d = (op_q.sa ^ op_q.sb) ? -dvd_d : dvd_d;
      rem_fix_d  = op_q.sa ? -prem_d : prem_d;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      prem_q  <= '0;
      dvd_q   <= '0;
      done_q  <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else if (div_flush) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (div_req) begin
            state_q   <= S_BUSY;
            cnt_q     <= '0;
            op_q.sa   <= sa_d;
            op_q.sb   <= sb_d;
            op_q.src1 <= div_src1;
            op_q.dvs  <= abs2_d;
            dvd_q     <= abs1_d;
            prem_q    <= '0;
          end
        end
        S_BUSY: begin
          prem_q <= prem_d;
          dvd_q  <= dvd_d;
          cnt_q  <= cnt_q + CW'(1);
          if (last_d) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            quot_q  <= quot_fix_d;
            rem_q   <= rem_fix_d;
          end
        end
        S_DONE: begin
          // Results hold while EX is frozen by another hazard; no recompute.
          if (div_ack || !div_req) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign div_stall = div_req & ~done_q;
  assign div_done  = done_q;
  assign div_quot  = quot_q;
  assign div_rem   = rem_q;

endmodule

// File: tb/tb_ex_iter_divider.sv
// Scoreboard bench for ex_iter_divider: the driver queues expected results from an arithmetic
// reference, a monitor pops and compares on each rising div_done.
module tb_ex_iter_divider;

  localparam int W = 32;
  localparam int LAT = W + 1;

  logic         clk, resetn;
  logic         div_req, div_signed, div_ack, div_flush;
  logic [W-1:0] div_src1, div_src2;
  logic         div_stall, div_done;
  logic [W-1:0] div_quot, div_rem;

  ex_iter_divider #(.WIDTH(W)) dut (
    .clk(clk), .resetn(resetn),
    .div_req(div_req), .div_signed(div_signed),
    .div_src1(div_src1), .div_src2(div_src2),
    .div_ack(div_ack), .div_flush(div_flush),
    .div_stall(div_stall), .div_done(div_done),
    .div_quot(div_quot), .div_rem(div_rem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: plain integer division with the architectural corner cases.
  function automatic logic [2*W-1:0] ref_div(input bit s, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa, sb;
    logic [W-1:0] q, r;
    if (b == 0) return {{W{1'b1}}, a};
    if (!s) return {a / b, a % b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h8000_0000, 32'h0};
    sa = a;
    sb = b;
    q = sa / sb;
    r = sa % sb;
    return {q, r};
  endfunction

  // Monitor
  logic done_prev = 1'b0;
  always @(negedge clk) begin
    exp_t e;
    if (div_done === 1'b1 && done_prev !== 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_done", {31'b0, div_done}, '0);
      end else begin
        e = exp_q.pop_front();
        chk("quot", div_quot, e.q);
        chk("rem", div_rem, e.r);
        chk("latency", W'(cyc - e.acc), W'(LAT));
      end
    end
    done_prev <= div_done;
  end

  // Issue one operation; hold extra DONE cycles, then leave via ack or by dropping req.
  task automatic run_op(input bit s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit leave_by_ack);
    logic [2*W-1:0] res;
    exp_t e;
    int stalls;
    res = ref_div(s, a, b);
    @(negedge clk);
    div_req = 1'b1; div_signed = s; div_src1 = a; div_src2 = b;
    e.q = res[2*W-1:W]; e.r = res[W-1:0]; e.acc = cyc;
    exp_q.push_back(e);
    #1;
    stalls = 0;
    for (int k = 0; k < 100 && div_done !== 1'b1; k++) begin
      if (div_stall === 1'b1) stalls++;
      @(negedge clk);
      if (k == 0) begin
        div_src1 = $urandom; div_src2 = $urandom; div_signed = ~s;
      end
    end
    if (div_done !== 1'b1) begin
      errors++;
      $display("FAIL timeout: div_done not seen for %0d/%0d", a, b);
      return;
    end
    chk("stall_cycles", W'(stalls), W'(LAT));
    chk("stall_in_done", {31'b0, div_stall}, '0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_done", {31'b0, div_done}, 32'd1);
      chk("hold_quot", div_quot, e.q);
      chk("hold_rem", div_rem, e.r);
    end
    if (leave_by_ack) div_ack = 1'b1;
    else              div_req = 1'b0;
    @(negedge clk);
    div_ack = 1'b0; div_req = 1'b0;
    chk("done_cleared", {31'b0, div_done}, '0);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return W'($urandom_range(0, 20));
      4: return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bit seen;
    resetn = 1'b0; div_req = 1'b0; div_signed = 1'b0; div_ack = 1'b0; div_flush = 1'b0;
    div_src1 = '0; div_src2 = '0;
    repeat (3) @(negedge clk);
    chk("rst_done", {31'b0, div_done}, '0);
    chk("rst_quot", div_quot, '0);
    chk("rst_rem", div_rem, '0);
    chk("rst_stall", {31'b0, div_stall}, '0);
    resetn = 1'b1;
    @(negedge clk);

    run_op(1'b0, 32'd100, 32'd7, 0, 1'b1);
    run_op(1'b1, -32'sd7, 32'd2, 0, 1'b1);
    run_op(1'b1, 32'd7, -32'sd2, 0, 1'b1);
    run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b1);
    run_op(1'b1, 32'h1234, 32'h0, 0, 1'b1);
    run_op(1'b0, 32'h1234, 32'h0, 0, 1'b1);
    run_op(1'b1, -32'sd9, 32'h0, 0, 1'b0);
    run_op(1'b0, $urandom, W'($urandom_range(1, 1000)), 5, 1'b1);

    // Flush in BUSY cycle 10, then flush racing a fresh req in IDLE
    @(negedge clk);
    div_req = 1'b1; div_signed = 1'b0; div_src1 = 32'd500; div_src2 = 32'd3;
    repeat (10) @(negedge clk);
    div_flush = 1'b1;
    @(negedge clk);
    @(negedge clk);
    div_flush = 1'b0; div_req = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (div_done === 1'b1) seen = 1'b1;
    end
    chk("flush_no_done", {31'b0, seen}, '0);
    run_op(1'b0, 32'hFFFF_FFFF, 32'h10, 0, 1'b1);

    // Reset in BUSY cycle 20
    @(negedge clk);
    div_req = 1'b1; div_signed = 1'b1; div_src1 = -32'sd1000; div_src2 = 32'd7;
    repeat (20) @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("arst_done", {31'b0, div_done}, '0);
    chk("arst_quot", div_quot, '0);
    chk("arst_rem", div_rem, '0);
    chk("arst_stall", {31'b0, div_stall}, 32'd1);
    @(negedge clk);
    resetn = 1'b1; div_req = 1'b0;
    run_op(1'b1, -32'sd1000, 32'd7, 0, 1'b1);

    for (int i = 0; i < 40; i++)
      run_op(1'($urandom_range(0, 1)), rand_operand(), rand_operand(),
             $urandom_range(0, 3), 1'($urandom_range(0, 1)));

    repeat (3) @(negedge clk);
    chk("queue_drained", W'(exp_q.size()), '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_iter_divider.md
# ex_iter_divider

Iterative 32-bit radix-2 restoring divider for the execute stage. It serves DIV.W, DIV.WU, MOD.W and MOD.WU, producing both quotient and remainder. Its `div_stall` output is the execute-stage divide-busy bit packed into the execute-to-hazard bus. That bit makes the hazard unit freeze fetch, decode and execute and insert a bubble into memory while a division runs.

## Interface
- `WIDTH`, 32, operand/result width; iteration count equals `WIDTH`; counter is clog2(`WIDTH`)+1 bits
- `clk` input 1 — sole clock, rising edge
- `resetn` input 1 — asynchronous, active-low reset
- `div_req` input 1 — a divide/mod instruction is valid in EX; held high while it stays in EX
- `div_signed` input 1 — 1: signed (DIV.W/MOD.W), 0: unsigned; sampled at accept
- `div_src1` input WIDTH — dividend; sampled at accept
- `div_src2` input WIDTH — divisor; sampled at accept
- `div_ack` input 1 — the EX instruction leaves EX this cycle
- `div_flush` input 1 — cancel any operation; the EX instruction is discarded
- `div_stall` output 1 — combinational; `div_req & ~div_done`; drives es_div_stall
- `div_done` output 1 — registered; results valid
- `div_quot` output WIDTH — registered quotient
- `div_rem` output WIDTH — registered remainder

## Operation
- States: IDLE, BUSY, DONE. Reset: IDLE; `div_done`=0; `div_quot`=0; `div_rem`=0; counter=0.
- IDLE:
  - `div_req & ~div_flush` → BUSY and counter=0.
  - Latch sign bits sa=`div_signed & src1[31]` and sb=`div_signed & src2[31]`.
  - Latch |src1| and |src2| (two's-complement negation when the sign bit is set), and zero the partial remainder.
- BUSY, each cycle:
  - Shift the {remainder, dividend} pair left by 1.
  - Trial-subtract the divisor on WIDTH+1 bits.
  - If the result is non-negative, keep it and set quotient bit 1; otherwise restore and set quotient bit 0.
  - Counter increments each cycle. After the WIDTH-th step, go to DONE.
- BUSY→DONE edge, sign fix-up registered into the outputs:
  - quot = (sa^sb) ? −q : q
  - rem = sa ? −r : r
  - `div_done`←1
- Divisor zero (any signedness): still runs the full WIDTH steps. Results are forced to quot=all-ones and rem=`div_src1` as latched.
- Signed overflow 0x80000000 / 0xFFFFFFFF: quot=0x80000000, rem=0. This falls out of the wrap and needs no special case.
- DONE holds the results and `div_done`=1 until `div_ack`, `div_flush` or `~div_req`, then goes to IDLE and clears `div_done` at that edge. Results are not recomputed when EX is held by another hazard.
- `div_flush` in any state → IDLE at the next edge and `div_done`←0. Flush beats `div_req` in the same cycle, so no start occurs.
- `div_quot`/`div_rem` keep their last value outside DONE; they are only meaningful when `div_done`=1.

## Timing
- Accept at cycle N (IDLE, `div_req`=1). BUSY occupies cycles N+1..N+WIDTH. `div_done`=1 from cycle N+WIDTH+1 (N+33 for 32 bits).
- `div_stall`=1 for cycles N..N+WIDTH (33 cycles). It is 0 in the first DONE cycle, so EX advances in that cycle if nothing else stalls.
- Back-to-back: a new `div_req` in the cycle after DONE→IDLE is accepted there. There is a minimum of 1 idle cycle between operations.
- Operand changes on `div_src1`/`div_src2` after accept have no effect.
- `resetn` low mid-operation: all state clears immediately. `div_stall` follows `div_req` (=`div_req`, since `div_done`=0).

## Test plan
- Unsigned 100 / 7, accept at cycle N → `div_stall` high for cycles N..N+32; `div_done` rises at N+33 with quot=14, rem=2.
- Signed operands, all checking `div_quot`/`div_rem` at `div_done`:
  - −7 / 2 → quot=0xFFFFFFFD, rem=0xFFFFFFFF.
  - 7 / −2 → quot=0xFFFFFFFD, rem=1.
  - 0x80000000 / 0xFFFFFFFF → quot=0x80000000, rem=0.
- Divide by zero: 0x1234 / 0, both signed and unsigned → quot=0xFFFFFFFF, rem=0x1234, after the full 33-cycle latency.
- DONE hold: keep `div_req`=1 and `div_ack`=0 for 5 cycles after done → `div_done` and results stay stable and no restart occurs. Then `div_ack`=1 → `div_done`=0 next cycle.
- Flush at BUSY cycle 10 → IDLE next cycle, `div_done` never rises. Then a new req 0xFFFFFFFF / 0x10 (unsigned) → a fresh 33-cycle run with quot=0x0FFFFFFF, rem=0xF.
- `resetn` pulsed low at BUSY cycle 20 → outputs are 0 immediately; after release, a new request completes normally.
